shot_board_writer: RTL

- Owns one player's 5x5 board state and is the writer of the cell matrices the VGA renderer reads (ship map, shot map).
- Loads a ship layout and counts its ship cells by serial scan.
- Accepts fire commands at (row, col) over a valid/ready handshake, resolves each as hit, miss or repeat, and updates the shot map.
- Tracks remaining ship cells and feeds the seven-segment counters and the win/lose logic.

---
 rtl/battleship_pkg.sv | 35 +++
 rtl/shot_board_writer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship board logic.
//   - Default board geometry and ship-counter width.
//   - Cell codes for the ship map and the shot map read by the VGA renderer.
//   - Shot result codes and the board-writer FSM state type.
package battleship_pkg;

  localparam int DEF_ROWS  = 5;
  localparam int DEF_COLS  = 5;
  localparam int DEF_CNT_W = 5;

  // Ship map cell codes
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;

  // Shot map cell codes
  localparam logic [1:0] SHOT_NONE = 2'b00;
  localparam logic [1:0] SHOT_MISS = 2'b01;
  localparam logic [1:0] SHOT_HIT  = 2'b10;

  typedef enum logic [1:0] {
    RES_MISS    = 2'b00,
    RES_HIT     = 2'b01,
    RES_REPEAT  = 2'b10,
    RES_INVALID = 2'b11
  } res_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CHECK,
    ST_WRITE,
    ST_REPORT
  } state_t;

endpackage

// File: rtl/shot_board_writer.sv
// Owns one player's board: loads a ship layout, counts its ship cells with
// a one-cell-per-cycle scan, resolves fire commands and keeps the ship and
// shot maps that the renderer reads.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   load_valid      request to load load_ships (accepted in IDLE, wins over fire)
//   load_ships      layout, bit r*COLS+c set = ship at (r,c)
//   load_ready      high in IDLE
//   fire_valid      fire command at (fire_row, fire_col)
//   fire_ready      high in IDLE once a layout has been loaded since reset
//   res_valid       one-cycle result pulse, res_code = miss/hit/repeat/invalid
//   ship_map        2 bits per cell at 2*(r*COLS+c): 01 ship, 00 water
//   shot_map        2 bits per cell: 00 untouched, 01 miss, 10 hit
//   ships_left      remaining un-hit ship cells
//   game_over       loaded and ships_left == 0
module shot_board_writer
  import battleship_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic [ROWS*COLS-1:0]     load_ships,
  output logic                     load_ready,
  input  logic                     fire_valid,
  input  logic [2:0]               fire_row,
  input  logic [2:0]               fire_col,
  output logic                     fire_ready,
  output logic                     res_valid,
  output logic [1:0]               res_code,
  output logic [2*ROWS*COLS-1:0]   ship_map,
  output logic [2*ROWS*COLS-1:0]   shot_map,
  output logic [CNT_W-1:0]         ships_left,
  output logic                     game_over
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  state_t            state, state_next;
  logic [CELLS-1:0]  ships_q;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        row_q, col_q;
  logic              loaded;
  res_code_t         code_q, code_calc;
  logic              coord_ok;
  logic [IDX_W-1:0]  cell_sel;
  logic [1:0]        shot_cell, ship_cell;

  function automatic logic [IDX_W-1:0] cell_index(input logic [2:0] r, input logic [2:0] c);
    return IDX_W'(int'(r) * COLS + int'(c));
  endfunction

  // Out-of-board coordinates select cell 0 so map reads stay in range; their
  // result is forced to invalid before the selected cell is ever looked at.
  assign coord_ok  = (int'(row_q) < ROWS) && (int'(col_q) < COLS);
  assign cell_sel  = coord_ok ? cell_index(row_q, col_q) : '0;
  assign shot_cell = shot_map[2*cell_sel +: 2];
  assign ship_cell = ship_map[2*cell_sel +: 2];

  assign res_code  = code_q;
  assign game_over = loaded && (ships_left == '0);

  // Shot resolution: invalid coordinates first, then a repeat on any already
  // marked cell, then hit or miss from the ship map.
  always_comb begin
    code_calc = RES_MISS;
    if (!coord_ok) begin
      code_calc = RES_INVALID;
    end else if (shot_cell != SHOT_NONE) begin
      code_calc = RES_REPEAT;
    end else if (ship_cell == CELL_SHIP) begin
      code_calc = RES_HIT;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. Fire is only honoured once a layout
  // exists, so an early fire command simply waits with fire_ready low.
  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    fire_ready = 1'b0;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        fire_ready = loaded;
        if (load_valid) begin
          state_next = ST_SCAN;
        end else if (fire_valid && loaded) begin
          state_next = ST_CHECK;
        end
      end
      ST_SCAN: begin
        if (idx == LAST_IDX) begin
          state_next = ST_IDLE;
        end
      end
      ST_CHECK:  state_next = ST_WRITE;
      ST_WRITE:  state_next = ST_REPORT;
      ST_REPORT: begin
        res_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Board datapath. The loaded flag drops while a new layout is scanned so
  // game_over cannot glitch high on the partially counted total.
  always_ff @(posedge clk) begin
    if (rst) begin
      ship_map   <= '0;
      shot_map   <= '0;
      ships_left <= '0;
      loaded     <= 1'b0;
      code_q     <= RES_MISS;
      idx        <= '0;
      ships_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            ships_q    <= load_ships;
            shot_map   <= '0;
            ships_left <= '0;
            idx        <= '0;
            loaded     <= 1'b0;
          end else if (fire_valid && loaded) begin
            row_q <= fire_row;
            col_q <= fire_col;
          end
        end
        ST_SCAN: begin
          ship_map[2*idx +: 2] <= ships_q[idx] ? CELL_SHIP : CELL_EMPTY;
          if (ships_q[idx]) begin
            ships_left <= ships_left + CNT_W'(1);
          end
          if (idx == LAST_IDX) begin
            loaded <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_CHECK: begin
          code_q <= code_calc;
        end
        ST_WRITE: begin
          case (code_q)
            RES_HIT: begin
              shot_map[2*cell_sel +: 2] <= SHOT_HIT;
              ships_left                <= ships_left - CNT_W'(1);
            end
            RES_MISS: begin
              shot_map[2*cell_sel +: 2] <= SHOT_MISS;
            end
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

endmodule
